// File: rtl/lcd_reader.sv
// HD44780-compatible LCD read engine, 8-bit bus mode.
// Runs single RW=1 read cycles of the busy flag/address counter (RS=0) or of
// data RAM (RS=1). Busy-poll mode repeats BF/AC reads until BF clears or the
// poll limit is reached. The FPGA never drives the LCD data bus from here.
module lcd_reader #(
  parameter int T_SETUP   = 2,
  parameter int T_EH      = 12,
  parameter int T_HOLD    = 2,
  parameter int T_GAP     = 13,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_timeout,
  input  logic [7:0] lcd_db_in,
  output logic       lcd_db_oe,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One shared phase counter, wide enough for the longest phase.
  localparam int CNT_MAX = max_of(max_of(T_SETUP, T_EH), max_of(T_HOLD, T_GAP));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EH_LD    = CNT_W'(T_EH - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(T_GAP - 1);
  localparam logic [7:0]       POLL_LIM = 8'(MAX_POLLS);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    E_HIGH,
    HOLD,
    GAP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       poll_cnt;
  logic             poll_q;
  logic [7:0]       sample;

  // The reader never drives the shared bus; RW=1 means the LCD owns it.
  assign lcd_db_oe = 1'b0;

  // Sample register holds bus data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == E_HIGH && cnt == '0) sample <= lcd_db_in;
  end

  // Read-cycle sequencer; every output is registered and set on state entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      poll_cnt   <= '0;
      poll_q     <= 1'b0;
      rd_ready   <= 1'b1;
      rd_data    <= 8'h00;
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_rw     <= 1'b0;
      lcd_e      <= 1'b0;
    end else begin
      rd_valid   <= 1'b0;
      rd_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            // Polling only makes sense for the busy flag, so RS=1 disables it.
            poll_q   <= rd_poll & ~rd_rs;
            poll_cnt <= '0;
            lcd_rs   <= rd_rs;
            lcd_rw   <= 1'b1;
            rd_ready <= 1'b0;
            cnt      <= SETUP_LD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            lcd_e <= 1'b1;
            cnt   <= EH_LD;
            state <= E_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        E_HIGH: begin
          if (cnt == '0) begin
            poll_cnt <= poll_cnt + 8'd1;
            lcd_e    <= 1'b0;
            cnt      <= HOLD_LD;
            state    <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            if (poll_q && sample[7] && (poll_cnt < POLL_LIM)) begin
              cnt   <= GAP_LD;
              state <= GAP;
            end else begin
              rd_data    <= sample;
              rd_valid   <= 1'b1;
              rd_timeout <= poll_q & sample[7];
              lcd_rw     <= 1'b0;
              lcd_rs     <= 1'b0;
              state      <= DONE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            cnt   <= SETUP_LD;
            state <= SETUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          rd_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          rd_ready <= 1'b1;
          lcd_e    <= 1'b0;
          lcd_rw   <= 1'b0;
          lcd_rs   <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Testbench for lcd_reader: cycle-level expected-waveform model plus
// per-transaction rule checks and directed test-plan scenarios.
module tb_lcd_reader;

  localparam int T_SETUP   = 2;
  localparam int T_EH      = 12;
  localparam int T_HOLD    = 2;
  localparam int T_GAP     = 13;
  localparam int MAX_POLLS = 4;
  localparam int READ_LEN  = T_SETUP + T_EH + T_HOLD;
  localparam int POLL_STEP = T_GAP + T_SETUP + T_EH + T_HOLD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_req = 1'b0;
  logic       rd_rs = 1'b0;
  logic       rd_poll = 1'b0;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_timeout;
  logic [7:0] lcd_db_in = 8'h00;
  logic       lcd_db_oe;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;

  int n_checks = 0;
  int n_fail   = 0;

  lcd_reader #(
    .T_SETUP  (T_SETUP),
    .T_EH     (T_EH),
    .T_HOLD   (T_HOLD),
    .T_GAP    (T_GAP),
    .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_rs     (rd_rs),
    .rd_poll   (rd_poll),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_timeout(rd_timeout),
    .lcd_db_in (lcd_db_in),
    .lcd_db_oe (lcd_db_oe),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- expected-waveform model ----------------
  typedef struct {
    logic       e;
    logic       rw;
    logic       rs;
    logic       ready;
    logic       valid;
    logic       tmo;
    logic       last_eh;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] last_data = 8'h00;
  logic       m_rs = 1'b0;
  logic       m_poll = 1'b0;
  int         m_reads = 0;
  bit         mvalid = 0;

  function automatic exp_t mk(input logic e, input logic rw, input logic rs,
                              input logic ready, input logic valid, input logic tmo,
                              input logic last_eh, input logic [7:0] data);
    exp_t x;
    x.e = e; x.rw = rw; x.rs = rs; x.ready = ready; x.valid = valid;
    x.tmo = tmo; x.last_eh = last_eh; x.data = data;
    return x;
  endfunction

  // One bus read as seen on the pins: setup with E low, then the E pulse.
  function automatic void push_read(input logic rs);
    for (int i = 0; i < T_SETUP; i++) q.push_back(mk(0, 1, rs, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < T_EH; i++)
      q.push_back(mk(1, 1, rs, 0, 0, 0, (i == T_EH - 1), 8'h00));
  endfunction

  function automatic void push_quiet(input int n, input logic rs);
    for (int i = 0; i < n; i++) q.push_back(mk(0, 1, rs, 0, 0, 0, 0, 8'h00));
  endfunction

  initial begin
    logic [7:0] smp;
    cur = mk(0, 0, 0, 1, 0, 0, 0, 8'h00);
    forever begin
      @(negedge clk);
      if (mvalid) begin
        chk("lcd_e", lcd_e, cur.e);
        chk("lcd_rw", lcd_rw, cur.rw);
        chk("lcd_rs", lcd_rs, cur.rs);
        chk("rd_ready", rd_ready, cur.ready);
        chk("rd_valid", rd_valid, cur.valid);
        chk("rd_timeout", rd_timeout, cur.tmo);
        chk("rd_data", rd_data, cur.data);
        chk("lcd_db_oe", lcd_db_oe, 1'b0);
      end
      // Inputs visible now are what the next rising edge samples.
      if (!rst_n) begin
        q.delete();
        last_data = 8'h00;
        cur = mk(0, 0, 0, 1, 0, 0, 0, 8'h00);
        mvalid = 1;
      end else begin
        if (cur.last_eh) begin
          smp = lcd_db_in;
          m_reads++;
          push_quiet(T_HOLD, m_rs);
          if (m_poll && smp[7] && m_reads < MAX_POLLS) begin
            push_quiet(T_GAP, m_rs);
            push_read(m_rs);
          end else begin
            q.push_back(mk(0, 0, 0, 0, 1, m_poll & smp[7], 0, smp));
          end
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else if (cur.ready && rd_req) begin
          m_rs    = rd_rs;
          m_poll  = rd_poll & ~rd_rs;
          m_reads = 0;
          push_read(m_rs);
          cur = q.pop_front();
        end else begin
          cur = mk(0, 0, 0, 1, 0, 0, 0, 8'h00);
        end
        if (cur.valid) last_data = cur.data;
        else cur.data = last_data;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] bus_tab [8];

  // Number of reads the rules demand for the current bus table.
  function automatic int reads_needed(input logic pe);
    if (!pe) return 1;
    for (int i = 0; i < MAX_POLLS; i++) if (!bus_tab[i][7]) return i + 1;
    return MAX_POLLS;
  endfunction

  // Issue one request and follow it to completion. Times are counted from the
  // accepting edge (cycle N), so the first observed cycle is N+1.
  task automatic run_txn(input logic rs, input logic poll, input bit junk,
                         output int lat, output int pulses, output int first_rise,
                         output int spacing, output logic [7:0] data, output logic tmo);
    int   idx = 0;
    int   cyc = 0;
    int   last_rise = -1;
    logic pe = 1'b0;
    bit   done = 0;
    lat = -1; pulses = 0; first_rise = -1; spacing = -1; data = 8'hxx; tmo = 1'bx;
    @(posedge clk); #1;
    rd_rs = rs; rd_poll = poll; rd_req = 1'b1; lcd_db_in = bus_tab[0];
    @(posedge clk); #1;
    rd_req = 1'b0;
    while (!done && cyc < 1000) begin
      if (lcd_e && !pe) begin
        pulses++;
        if (last_rise >= 0) spacing = cyc - last_rise;
        else first_rise = cyc + 1;
        last_rise = cyc;
      end
      if (!lcd_e && pe) begin
        idx++;
        lcd_db_in = bus_tab[(idx < 8) ? idx : 7];
      end
      pe = lcd_e;
      if (rd_valid) begin
        done = 1;
        lat  = cyc + 1;
        data = rd_data;
        tmo  = rd_timeout;
      end else begin
        if (junk) rd_req = ($urandom_range(0, 3) == 0);
        @(posedge clk); #1;
        cyc++;
      end
    end
    rd_req = 1'b0;
    if (!done) chk("txn_completes", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int         lat, pulses, fr, sp, n, k, cnt_v, cnt_nr, cnt_e;
    logic [7:0] d;
    logic       t, pe;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_reset", rd_ready, 1);
    chk("data_after_reset", rd_data, 8'h00);

    // Single data read.
    for (int i = 0; i < 8; i++) bus_tab[i] = 8'hA5;
    run_txn(1'b1, 1'b0, 0, lat, pulses, fr, sp, d, t);
    chk("dr_latency", lat, 17);
    chk("dr_e_rise", fr, 3);
    chk("dr_pulses", pulses, 1);
    chk("dr_data", d, 8'hA5);
    chk("dr_timeout", t, 0);

    // Reset during E_HIGH.
    @(posedge clk); #1;
    rd_rs = 1'b1; rd_poll = 1'b0; rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
    k = 0;
    while (!lcd_e && k < 20) begin @(posedge clk); #1; k++; end
    chk("rst_e_reached", lcd_e, 1);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_e_low", lcd_e, 0);
    chk("rst_rw_low", lcd_rw, 0);
    chk("rst_rs_low", lcd_rs, 0);
    chk("rst_ready", rd_ready, 1);
    chk("rst_data", rd_data, 8'h00);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    cnt_v = 0; cnt_nr = 0; cnt_e = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (rd_valid) cnt_v++;
      if (!rd_ready) cnt_nr++;
      if (lcd_e) cnt_e++;
    end
    chk("rst_no_valid", cnt_v, 0);
    chk("rst_stays_ready", cnt_nr, 0);
    chk("rst_no_e", cnt_e, 0);

    // BF read without poll.
    for (int i = 0; i < 8; i++) bus_tab[i] = 8'h8C;
    run_txn(1'b0, 1'b0, 0, lat, pulses, fr, sp, d, t);
    chk("bf_pulses", pulses, 1);
    chk("bf_data", d, 8'h8C);
    chk("bf_timeout", t, 0);

    // Busy poll that clears on the fourth read.
    bus_tab[0] = 8'h80; bus_tab[1] = 8'h80; bus_tab[2] = 8'h80;
    for (int i = 3; i < 8; i++) bus_tab[i] = 8'h05;
    run_txn(1'b0, 1'b1, 0, lat, pulses, fr, sp, d, t);
    chk("poll_pulses", pulses, 4);
    chk("poll_spacing", sp, 29);
    chk("poll_latency", lat, 17 + 3 * 29);
    chk("poll_data", d, 8'h05);
    chk("poll_timeout", t, 0);

    // Poll limit exhausted.
    for (int i = 0; i < 8; i++) bus_tab[i] = 8'hFF;
    run_txn(1'b0, 1'b1, 0, lat, pulses, fr, sp, d, t);
    chk("tmo_pulses", pulses, 4);
    chk("tmo_data", d, 8'hFF);
    chk("tmo_timeout", t, 1);

    // Poll requested with RS=1 gives a single read; junk requests ignored.
    for (int i = 0; i < 8; i++) bus_tab[i] = 8'h80;
    run_txn(1'b1, 1'b1, 1, lat, pulses, fr, sp, d, t);
    chk("rs1_poll_pulses", pulses, 1);
    chk("rs1_poll_data", d, 8'h80);
    chk("rs1_poll_timeout", t, 0);
    cnt_e = 0; pe = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (lcd_e && !pe) cnt_e++;
      pe = lcd_e;
    end
    chk("no_queued_txn", cnt_e, 0);

    // Randomized transactions checked against the read-count rules.
    for (int r = 0; r < 24; r++) begin
      logic rs_r, poll_r;
      rs_r   = 1'($urandom_range(0, 1));
      poll_r = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++)
        bus_tab[i] = {($urandom_range(0, 9) < 6), 7'($urandom)};
      n = reads_needed(poll_r & ~rs_r);
      run_txn(rs_r, poll_r, 1, lat, pulses, fr, sp, d, t);
      chk("rnd_pulses", pulses, n);
      chk("rnd_latency", lat, READ_LEN + 1 + (n - 1) * POLL_STEP);
      chk("rnd_data", d, bus_tab[n - 1]);
      chk("rnd_timeout", t, poll_r & ~rs_r & bus_tab[n - 1][7]);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
